// File: rtl/matrix_scan_pkg.sv
// Shared types and default geometry for the RGB panel scan controller.
// Optional brightness PWM is enabled by defining MATRIX_SCAN_BRIGHTNESS_EN.
package matrix_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_e;

  localparam int DEF_COLS        = 60;
  localparam int DEF_ROWS        = 16;
  localparam int DEF_DISP_CYCLES = 64;

endpackage

// File: rtl/matrix_scan_ctrl_oe.sv
// matrix_oe_pwm: DISPLAY-phase down-counter driving the panel output enable.
// With MATRIX_SCAN_BRIGHTNESS_EN the enable is cut short by a brightness compare.
module matrix_oe_pwm
  import matrix_scan_pkg::*;
#(
  parameter int  DISP_CYCLES = DEF_DISP_CYCLES,
  localparam int CW          = $clog2(DISP_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  input  logic [7:0] brightness,
`endif
  output logic       oe_n,
  output logic       done
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          lit;

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  logic [CW-1:0] on_q, on_d;

  // Lit while elapsed cycles (DISP_CYCLES-1-cnt) are below the on-time.
  always_comb begin
    on_d = on_q;
    if (start) on_d = CW'((DISP_CYCLES * 32'(brightness)) >> 8);
    lit = ({1'b0, cnt_q} + {1'b0, on_q}) >= (CW + 1)'(DISP_CYCLES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) on_q <= '0;
    else      on_q <= on_d;
  end
`else
  assign lit = 1'b1;
`endif

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      cnt_d    = CW'(DISP_CYCLES - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - 1'b1;
    end
    done = active_q && (cnt_q == '0);
    oe_n = !(active_q && lit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for the dual-half RGB LED panel: shift, blank, latch, display per row.
// Define MATRIX_SCAN_BRIGHTNESS_EN to add the brightness input and OE PWM.
module matrix_scan_ctrl
  import matrix_scan_pkg::*;
#(
  parameter int  COLS        = DEF_COLS,
  parameter int  ROWS        = DEF_ROWS,
  parameter int  DISP_CYCLES = DEF_DISP_CYCLES,
  localparam int CW          = $clog2(COLS),
  localparam int RW          = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  input  logic [7:0]    brightness,
`endif
  input  logic          r0_in,
  input  logic          g0_in,
  input  logic          b0_in,
  input  logic          r1_in,
  input  logic          g1_in,
  input  logic          b1_in,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          panel_r0,
  output logic          panel_g0,
  output logic          panel_b0,
  output logic          panel_r1,
  output logic          panel_g1,
  output logic          panel_b1,
  output logic          panel_clk,
  output logic          panel_lat,
  output logic          panel_oe_n,
  output logic          frame_start
);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  scan_state_e   state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          phase_q, phase_d;
  logic [5:0]    pix_q, pix_d;
  logic          panel_clk_q, panel_clk_d;
  logic          panel_lat_q, panel_lat_d;
  logic          frame_start_q, frame_start_d;
  logic          oe_done;
  logic [5:0]    pix_in;

  assign pix_in = {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    pix_d   = pix_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ST_SHIFT;
          phase_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (!phase_q) begin
          pix_d   = pix_in;
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = ST_BLANK;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_BLANK:   state_d = ST_LATCH;
      ST_LATCH:   state_d = ST_DISPLAY;
      ST_DISPLAY: begin
        if (oe_done) begin
          // en is only honoured at row boundaries so a row is never cut short.
          if (en) begin
            state_d = ST_SHIFT;
            row_d   = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
          end else begin
            state_d = ST_IDLE;
            row_d   = '0;
            col_d   = '0;
            pix_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Pin strobes are registered from the next state so they align with state_q.
    panel_clk_d   = (state_d == ST_SHIFT) && phase_d;
    panel_lat_d   = (state_d == ST_LATCH);
    frame_start_d = (state_d == ST_SHIFT) && (state_q != ST_SHIFT) && (row_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      phase_q       <= 1'b0;
      pix_q         <= '0;
      panel_clk_q   <= 1'b0;
      panel_lat_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      phase_q       <= phase_d;
      pix_q         <= pix_d;
      panel_clk_q   <= panel_clk_d;
      panel_lat_q   <= panel_lat_d;
      frame_start_q <= frame_start_d;
    end
  end

  matrix_oe_pwm #(
    .DISP_CYCLES(DISP_CYCLES)
  ) u_oe_pwm (
    .clk       (clk),
    .rst       (rst),
    .start     (state_q == ST_LATCH),
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .oe_n      (panel_oe_n),
    .done      (oe_done)
  );

  assign col         = col_q;
  assign row         = row_q;
  assign {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} = pix_q;
  assign panel_clk   = panel_clk_q;
  assign panel_lat   = panel_lat_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl with COLS=4, ROWS=2, DISP_CYCLES=8 (18 cycles/row).
// Brightness checks run only when MATRIX_SCAN_BRIGHTNESS_EN is defined.
module tb_matrix_scan_ctrl;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int DISP = 8;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  localparam int ON_MAIN = 7;  // brightness 255 -> (8*255)>>8
`else
  localparam int ON_MAIN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  logic [7:0] brightness;
`endif
  logic       r0_in, g0_in, b0_in, r1_in, g1_in, b1_in;
  logic [1:0] col;
  logic [0:0] row;
  logic       panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1;
  logic       panel_clk, panel_lat, panel_oe_n, frame_start;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Datapath model: pixel bits derived from the presented col/row.
  assign r0_in = col[0];
  assign g0_in = col[1];
  assign b0_in = row[0];
  assign r1_in = ~col[0];
  assign g1_in = 1'b1;
  assign b1_in = 1'b0;

  matrix_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .DISP_CYCLES(DISP)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .r0_in(r0_in), .g0_in(g0_in), .b0_in(b0_in),
    .r1_in(r1_in), .g1_in(g1_in), .b1_in(b1_in),
    .col(col), .row(row),
    .panel_r0(panel_r0), .panel_g0(panel_g0), .panel_b0(panel_b0),
    .panel_r1(panel_r1), .panel_g1(panel_g1), .panel_b1(panel_b1),
    .panel_clk(panel_clk), .panel_lat(panel_lat),
    .panel_oe_n(panel_oe_n), .frame_start(frame_start)
  );

  logic [6:0] obs_vec;
  logic [5:0] obs_pix;
  assign obs_vec = {col, row, panel_clk, panel_lat, panel_oe_n, frame_start};
  assign obs_pix = {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1};

  localparam logic [6:0] IDLE_VEC = 7'b00_0_0_0_1_0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {col,row,clk,lat,oe_n,frame_start} kk cycles after the first SHIFT cycle.
  function automatic logic [6:0] exp_vec(input int kk, input int on);
    int p;
    logic [1:0] c;
    logic r, ck, lt, oe, fs;
    p  = kk % 18;
    r  = ((kk / 18) % 2) == 1;
    c  = (p < 8) ? 2'(p / 2) : 2'd0;
    ck = (p < 8) && (p % 2 == 1);
    lt = (p == 9);
    oe = !((p >= 10) && (p - 10 < on));
    fs = (kk % 36 == 0);
    return {c, r, ck, lt, oe, fs};
  endfunction

  function automatic logic [5:0] exp_pix(input int kk);
    logic [1:0] c;
    logic r;
    c = 2'((kk % 18) / 2);
    r = ((kk / 18) % 2) == 1;
    return {c[0], c[1], r, ~c[0], 1'b1, 1'b0};
  endfunction

  initial begin
    int kk;
    logic [6:0] ev;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    logic [7:0] bvals [3];
    int         lows  [3];
    int low_cnt, fs_at;
    bvals = '{8'd128, 8'd0, 8'd255};
    lows  = '{4, 0, 7};
    brightness = 8'd255;
`endif
    rst = 1'b0;
    en  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_vec", 32'(obs_vec), 32'(IDLE_VEC));
    chk("reset_pix", 32'(obs_pix), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_vec", 32'(obs_vec), 32'(IDLE_VEC));
    end
    $display("idle hold done: 20 cycles");

    // Scan, drop en in row 1 col 2, idle, resume, glitch en mid-row, reset in DISPLAY.
    en = 1'b1;
    for (int k = 0; k <= 143; k++) begin
      @(negedge clk);
      if (k >= 108 && k < 113) begin
        chk("idle_after_drop", 32'(obs_vec), 32'(IDLE_VEC));
        chk("idle_pix_clear", 32'(obs_pix), 32'd0);
      end else begin
        kk = (k < 108) ? k : k - 113;
        ev = exp_vec(kk, ON_MAIN);
        chk("scan_vec", 32'(obs_vec), 32'(ev));
        if (ev[3]) chk("scan_pix", 32'(obs_pix), 32'(exp_pix(kk)));
      end
      if (k == 94)  en = 1'b0;
      if (k == 112) en = 1'b1;
      if (k == 115) en = 1'b0;
      if (k == 119) en = 1'b1;
    end
    $display("scan sequence done: 144 cycles");

    chk("pre_reset_oe_low", 32'(panel_oe_n), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_vec", 32'(obs_vec), 32'(IDLE_VEC));
    chk("async_reset_pix", 32'(obs_pix), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(obs_vec), 32'(IDLE_VEC));
    $display("async reset in DISPLAY done");

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    for (int b = 0; b < 3; b++) begin
      rst = 1'b0;
      en  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      brightness = bvals[b];
      en = 1'b1;
      low_cnt = 0;
      fs_at   = -1;
      for (int k = 0; k < 37; k++) begin
        @(negedge clk);
        if (k < 36 && !panel_oe_n) low_cnt++;
        if (k > 0 && frame_start && fs_at < 0) fs_at = k;
      end
      chk("bright_low_cycles", 32'(low_cnt), 32'(2 * lows[b]));
      chk("bright_frame_period", 32'(fs_at), 32'd36);
      $display("brightness %0d: low cycles per frame %0d", bvals[b], low_cnt);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
